booth_pp_generator: RTL
=======================

// Module: booth_pp_generator
// PURPOSE
// - Radix-4 Booth partial-product generator; the stage directly upstream of wallace_addition.
// - Accepts an unsigned WIDTH-bit multiplicand/multiplier pair over a valid/ready handshake.
// - Generates one partial product per cycle: NPP = WIDTH/2+1 products, each 2*WIDTH bits.
// - Holds the full set stable for the adder tree (pp0 -> _0PP ... pp4 -> _4PP at WIDTH=8).
// PARAMETERS
// - WIDTH  8  operand width; must be even and >= 4
// - NPP    localparam = WIDTH/2+1; number of partial products (5 at default)
// - PPW    localparam = 2*WIDTH; partial-product width (16 at default)
// PORTS
// - clk        in   1         rising-edge clock
// - rst_n      in   1         asynchronous, active-low reset
// - in_valid   in   1         operands valid
// - in_ready   out  1         block can accept operands
// - a          in   WIDTH     multiplicand, unsigned
// - b          in   WIDTH     multiplier, unsigned
// - out_valid  out  1         pp_flat holds a complete set
// - out_ready  in   1         consumer accepts pp_flat
// - pp_flat    out  NPP*PPW   slot i = pp_flat[i*PPW +: PPW]; pp0 sits at the LSBs
// - busy       out  1         1 in GEN state
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE, cnt=0, a/b regs=0, pp_flat=0.
//   - out_valid=0, busy=0, in_ready=1 once out of reset.
// - Multiplier extension: B = {2'b00, b_reg}, with B[-1]=0.
// - Triplet i = {B[2i+1], B[2i], B[2i-1]}, for i = 0..NPP-1.
// - Digit decode:
//   - 000, 111 -> 0
//   - 001, 010 -> +1
//   - 011 -> +2
//   - 100 -> -2
//   - 101, 110 -> -1
// - Slot i value = (digit * a_reg) as a full two's-complement PPW-bit value, << 2i, truncated to PPW.
//   - No separate +1 correction term.
//   - Sum of all slots mod 2^PPW == a*b exactly.
// - FSM:
//   - IDLE: in_ready=1. On in_valid&&in_ready: latch a,b; clear pp_flat; cnt<=0; go to GEN.
//   - GEN: each cycle write slot[cnt]; cnt<=cnt+1. At cnt==NPP-1, write the last slot and go to DONE.
//   - DONE: out_valid=1 and pp_flat frozen. On out_ready go to IDLE (out_valid low the next cycle).
// - Timing:
//   - in_ready=0 in GEN and DONE (without the macro).
//   - Latency: handshake at edge E0 -> out_valid high after edge E0+NPP (5 at default).
//   - Without back-to-back acceptance, throughput is at most one set every NPP+2 cycles.
//   - pp_flat changes only in GEN; values are stable in DONE and IDLE.
//   - a/b inputs are ignored outside the accepting handshake; changes mid-GEN have no effect.
// - Boundary conditions:
//   - out_ready high while not in DONE is ignored.
//   - in_valid held through GEN/DONE is not consumed until in_ready=1.
//   - b=0 or a=0 gives all slots 0; the FSM still runs the full NPP cycles (no early exit).
//   - Reset mid-GEN or in DONE aborts immediately: outputs go to reset values and the set is lost.
// CONFIGURATION
// - BOOTH_BACK2BACK_EN
//   - Defined: in DONE, in_ready=out_ready.
//   - Defined: out_valid&&out_ready&&in_valid in the same cycle latches new operands, clears pp_flat, sets cnt=0 and goes straight to GEN.
//   - Defined: throughput is one set per NPP+1 cycles.
//   - Undefined: in_ready=0 in DONE; a mandatory IDLE cycle separates sets.
// TESTING
// - Reset: rst_n=0 async mid-cycle -> out_valid=0, busy=0, pp_flat=0 with no clock edge; in_ready=1 after release.
// - a=5, b=3, out_ready=1 -> after 5 cycles out_valid=1:
//   - pp0=16'hFFFB, pp1=16'h0014, pp2..pp4=0; sum mod 2^16 = 15.
// - a=255, b=255:
//   - pp0=16'hFF01, pp1=pp2=pp3=0, pp4=16'hFF00; sum mod 2^16 = 16'hFE01 (65025).
// - a=200, b=0 -> all slots 0; out_valid still asserted exactly 5 cycles after the handshake.
// - Backpressure: out_ready=0 for 10 cycles in DONE:
//   - pp_flat and out_valid held stable; in_ready=0.
//   - A new in_valid pair is not accepted until after out_ready=1.
// - Reset at cnt=2 of a=5, b=3 -> IDLE, pp_flat=0.
//   - Next pair a=7, b=9 produces a correct set summing to 63.
// - BOOTH_BACK2BACK_EN defined: out_ready=1 and in_valid=1 with a=3, b=3 in DONE:
//   - GEN entered the next cycle; second set valid 6 cycles after the first.

Source files
------------

// File: rtl/booth_pp_generator.sv
// Radix-4 Booth partial-product generator: emits one partial product per cycle into a held bank.
// Optional BOOTH_BACK2BACK_EN lets a new operand pair be accepted in the same cycle the set is consumed.
module booth_pp_generator #(
  parameter int WIDTH = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [WIDTH-1:0]                        a,
  input  logic [WIDTH-1:0]                        b,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [(WIDTH/2+1)*(2*WIDTH)-1:0]        pp_flat,
  output logic                                    busy
);

  localparam int NPP  = WIDTH / 2 + 1;
  localparam int PPW  = 2 * WIDTH;
  localparam int CNTW = $clog2(NPP);
  localparam int BXW  = WIDTH + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [NPP*PPW-1:0]     pp_q, pp_d;

  logic [BXW-1:0]         b_ext;
  logic [2:0]             triplet;
  logic [PPW-1:0]         a_ext;
  logic [PPW-1:0]         prod;
  logic [PPW-1:0]         slot_val;
  logic                   accept;

  // Two zero bits above the multiplier keep it unsigned; the bit below is B[-1].
  assign b_ext   = {2'b00, b_q, 1'b0};
  assign triplet = 3'(b_ext >> {cnt_q, 1'b0});
  assign a_ext   = {{WIDTH{1'b0}}, a_q};

  always_comb begin
    prod = '0;
    unique case (triplet)
      3'b001, 3'b010: prod = a_ext;
      3'b011:         prod = a_ext << 1;
      3'b100:         prod = -(a_ext << 1);
      3'b101, 3'b110: prod = -a_ext;
      default:        prod = '0;
    endcase
  end

  assign slot_val = prod << {cnt_q, 1'b0};

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    pp_d     = pp_q;
    in_ready = 1'b0;
    accept   = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end

      GEN: begin
        for (int i = 0; i < NPP; i++) begin
          if (cnt_q == CNTW'(i)) pp_d[i*PPW +: PPW] = slot_val;
        end
        if (cnt_q == CNTW'(NPP - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
`ifdef BOOTH_BACK2BACK_EN
        in_ready = out_ready;
        accept   = out_ready && in_valid;
        if (out_ready && !in_valid) state_d = IDLE;
`else
        if (out_ready) state_d = IDLE;
`endif
      end

      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d     = a;
      b_d     = b;
      pp_d    = '0;
      cnt_d   = '0;
      state_d = GEN;
    end
  end

  // NOTE: the partial-product bank is an array of registers, but it is reset like any other
  // state because a reset must leave pp_flat at zero rather than at stale products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pp_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pp_q    <= pp_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == GEN);
  assign pp_flat   = pp_q;

endmodule
